// File: rtl/ni_pkg.sv
// Shared NI types and defaults.
// Used by the injection scheduler and its arbiter.
package ni_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ni_state_e;

  localparam int NI_NUM_REQ   = 4;
  localparam int NI_DATA_W    = 32;
  localparam int NI_MAX_FLITS = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NI_GID_W = idx_w(NI_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Searches ptr+1, ptr+2, ... modulo N.
module rr_arbiter
  import ni_pkg::*;
#(
  parameter int N  = NI_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] k;

  // first requester after ptr wins
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    k          = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found         = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = k;
      end
    end
  end

endmodule

// File: rtl/ni_inject_scheduler.sv
// NI injection port scheduler.
// Round-robin, wormhole grant hold, phase gated.
module ni_inject_scheduler
  import ni_pkg::*;
#(
  parameter  int NUM_REQ   = NI_NUM_REQ,
  parameter  int DATA_W    = NI_DATA_W,
  parameter  int MAX_FLITS = NI_MAX_FLITS,
  localparam int GID_W     = idx_w(NUM_REQ),
  localparam int CNT_W     = idx_w(MAX_FLITS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      len_err
);

  ni_state_e          state;
  ni_state_e          state_nxt;
  logic [GID_W-1:0]   rr_ptr;
  logic [GID_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic               arb_any;
  logic [CNT_W-1:0]   flit_cnt;
  logic               cnt_max;
  logic               xfer;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (GID_W)
  ) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_oh),
    .gnt_idx    (arb_idx)
  );

  assign arb_any = |arb_oh;
  assign cnt_max = (flit_cnt == CNT_W'(MAX_FLITS - 1));
  assign xfer    = out_valid & out_ready;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and port outputs from the grant
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (mode_i && arb_any) state_nxt = SEND;
      end
      SEND: begin
        out_valid = mode_i & req_valid[grant_id];
        out_data  = req_data[int'(grant_id)*DATA_W +: DATA_W];
        out_last  = req_last[grant_id] | cnt_max;
        req_ready[grant_id] = mode_i & out_ready;
        if (out_valid && out_ready && out_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant, pointer, flit count and guard pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= GID_W'(NUM_REQ - 1);
      flit_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (state == IDLE) begin
        if (mode_i && arb_any) begin
          grant_id <= arb_idx;
          busy     <= 1'b1;
          flit_cnt <= '0;
        end
      end else if (xfer) begin
        if (out_last) begin
          rr_ptr   <= grant_id;
          busy     <= 1'b0;
          flit_cnt <= '0;
          len_err  <= ~req_last[grant_id];
        end else begin
          flit_cnt <= flit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ni_inject_scheduler.sv
// Randomized bench for ni_inject_scheduler.
// Packet-level reference model with per-source flit queues.
module tb_ni_inject_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MF = 16;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             mode_i;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             len_err;

  ni_inject_scheduler #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .MAX_FLITS (MF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode_i    (mode_i),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  // source flit queues: {last, data}
  logic [W:0] srcq [N][$];

  // reference model state
  bit m_busy;
  int m_g;
  int m_cnt;
  int m_ptr;
  bit m_err;

  // observations from the DUT
  int obs_xfers;
  int obs_pkts;
  int obs_errs;
  int pushed;
  int first_last_idx;
  int flit_idx;
  bit prev_busy;
  int glog[$];

  int n_chk;
  int n_pass;

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_cnt  = 0;
    m_ptr  = N - 1;
    m_err  = 1'b0;
  endtask

  task automatic push_pkt(input int src, input int len, input bit lst);
    logic [W:0] f;
    for (int i = 0; i < len; i++) begin
      f[W-1:0] = W'($urandom);
      f[W]     = lst && (i == len - 1);
      srcq[src].push_back(f);
    end
    pushed += len;
  endtask

  task automatic step(input bit mode, input bit rdy, input logic [N-1:0] bub);
    logic [N-1:0] vld;
    logic [W:0]   head;
    logic [W:0]   hd;
    bit           hv;
    bit           exp_valid;
    bit           exp_last;
    logic [W-1:0] exp_data;
    logic [N-1:0] exp_ready;
    bit           xf;
    bit           nerr;
    bit           fnd;
    int           c;
    @(negedge clk);
    mode_i    = mode;
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      hv = srcq[i].size() != 0;
      hd = hv ? srcq[i][0] : '0;
      req_valid[i]       = hv && !bub[i];
      req_data[i*W +: W] = hd[W-1:0];
      req_last[i]        = hd[W];
    end
    vld = req_valid;
    #1;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    exp_data  = '0;
    exp_ready = '0;
    head      = '0;
    if (m_busy) begin
      if (srcq[m_g].size() != 0) head = srcq[m_g][0];
      exp_valid = mode && vld[m_g];
      exp_data  = head[W-1:0];
      exp_last  = head[W] || (m_cnt == MF - 1);
      if (mode && rdy) exp_ready[m_g] = 1'b1;
    end
    n_chk++;
    if (busy !== m_busy)
      $display("FAIL busy: got %b want %b t=%0t", busy, m_busy, $time);
    else n_pass++;
    n_chk++;
    if (len_err !== m_err)
      $display("FAIL len_err: got %b want %b t=%0t", len_err, m_err, $time);
    else n_pass++;
    n_chk++;
    if (out_valid !== exp_valid)
      $display("FAIL out_valid: got %b want %b t=%0t", out_valid, exp_valid, $time);
    else n_pass++;
    n_chk++;
    if (req_ready !== exp_ready)
      $display("FAIL req_ready: got %b want %b t=%0t", req_ready, exp_ready, $time);
    else n_pass++;
    if (m_busy) begin
      n_chk++;
      if (int'(grant_id) !== m_g)
        $display("FAIL grant_id: got %0d want %0d t=%0t", grant_id, m_g, $time);
      else n_pass++;
    end
    if (exp_valid) begin
      n_chk++;
      if (out_data !== exp_data)
        $display("FAIL out_data: got %h want %h t=%0t", out_data, exp_data, $time);
      else n_pass++;
      n_chk++;
      if (out_last !== exp_last)
        $display("FAIL out_last: got %b want %b t=%0t", out_last, exp_last, $time);
      else n_pass++;
    end
    // DUT-side observations
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (len_err) obs_errs++;
    if (out_valid && out_ready) begin
      obs_xfers++;
      flit_idx++;
      if (out_last) begin
        obs_pkts++;
        if (first_last_idx == 0) first_last_idx = flit_idx;
      end
    end
    // advance the model across the coming edge
    xf   = exp_valid && rdy;
    nerr = 1'b0;
    if (!m_busy) begin
      if (mode && (vld != '0)) begin
        fnd = 1'b0;
        for (int i = 1; i <= N; i++) begin
          c = (m_ptr + i) % N;
          if (!fnd && vld[c]) begin
            fnd = 1'b1;
            m_g = c;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (xf) begin
      void'(srcq[m_g].pop_front());
      if (exp_last) begin
        m_busy = 1'b0;
        m_ptr  = m_g;
        m_cnt  = 0;
        nerr   = !head[W];
      end else begin
        m_cnt++;
      end
    end
    m_err = nerr;
  endtask

  task automatic drain(input int maxc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      step(1'b1, 1'b1, '0);
      done = !m_busy && !m_err;
      for (int i = 0; i < N; i++)
        if (srcq[i].size() != 0) done = 1'b0;
    end
    step(1'b1, 1'b1, '0);
    n_chk++;
    if (obs_xfers !== pushed)
      $display("FAIL drain: transfers %0d want %0d", obs_xfers, pushed);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mode_i    = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (grant_id !== '0) $display("FAIL rst_grant: got %0d want 0", grant_id);
    else n_pass++;
    n_chk++;
    if (len_err !== 1'b0) $display("FAIL rst_len_err: got %b want 0", len_err);
    else n_pass++;
    n_chk++;
    if (req_ready !== '0) $display("FAIL rst_req_ready: got %b want 0", req_ready);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    push_pkt(2, 8, 1'b1);
    repeat (5) step(1'b1, 1'b1, '0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (len_err !== 1'b0) $display("FAIL midrst_len_err: got %b want 0", len_err);
    else n_pass++;
    model_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    pushed    = obs_xfers;
    prev_busy = 1'b0;
    mode_i    = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) push_pkt(i, 1, 1'b1);
    glog.delete();
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    n_chk++;
    if (grant_id !== 2'd0) $display("FAIL rst_first_winner: got %0d want 0", grant_id);
    else n_pass++;
    drain(100);
  endtask

  task automatic test_fairness();
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_pkt(i, 2, 1'b1);
    drain(100);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= glog.size())
        $display("FAIL fair_order[%0d]: got none want %0d", i, exp_order[i]);
      else if (glog[i] !== exp_order[i])
        $display("FAIL fair_order[%0d]: got %0d want %0d", i, glog[i], exp_order[i]);
      else n_pass++;
    end
  endtask

  task automatic test_phase_hold();
    int x0;
    x0 = obs_xfers;
    push_pkt(2, 4, 1'b1);
    repeat (3) step(1'b1, 1'b1, '0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, '0);
      n_chk++;
      if (grant_id !== 2'd2) $display("FAIL hold_grant: got %0d want 2", grant_id);
      else n_pass++;
      n_chk++;
      if (req_ready !== '0) $display("FAIL hold_ready: got %b want 0", req_ready);
      else n_pass++;
    end
    n_chk++;
    if (obs_xfers - x0 !== 2)
      $display("FAIL hold_count: got %0d want 2", obs_xfers - x0);
    else n_pass++;
    drain(50);
  endtask

  task automatic test_backpressure();
    int x0;
    x0 = obs_xfers;
    push_pkt(1, 6, 1'b1);
    push_pkt(0, 3, 1'b1);
    for (int k = 0; k < 60; k++)
      step(1'b1, k[0] == 1'b0, N'($urandom_range(0, 1) << 1));
    drain(100);
    n_chk++;
    if (obs_xfers - x0 !== 9)
      $display("FAIL bp_count: got %0d want 9", obs_xfers - x0);
    else n_pass++;
  endtask

  task automatic test_len_guard();
    int e0;
    int p0;
    e0 = obs_errs;
    p0 = obs_pkts;
    flit_idx       = 0;
    first_last_idx = 0;
    push_pkt(3, 20, 1'b1);
    drain(100);
    n_chk++;
    if (first_last_idx !== MF)
      $display("FAIL guard_last_idx: got %0d want %0d", first_last_idx, MF);
    else n_pass++;
    n_chk++;
    if (obs_errs - e0 !== 1)
      $display("FAIL guard_err_pulses: got %0d want 1", obs_errs - e0);
    else n_pass++;
    n_chk++;
    if (obs_pkts - p0 !== 2)
      $display("FAIL guard_packets: got %0d want 2", obs_pkts - p0);
    else n_pass++;
  endtask

  task automatic test_idle_phase();
    push_pkt(0, 2, 1'b1);
    push_pkt(2, 1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, '0);
      n_chk++;
      if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
      else n_pass++;
    end
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL idle_arb: got %b want 1", busy);
    else n_pass++;
    drain(50);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20)
                                          : $urandom_range(1, 4);
        push_pkt($urandom_range(0, N - 1), len, 1'b1);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           N'($urandom) & N'($urandom));
    end
    drain(2000);
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    obs_xfers      = 0;
    obs_pkts       = 0;
    obs_errs       = 0;
    pushed         = 0;
    flit_idx       = 0;
    first_last_idx = 0;
    prev_busy      = 1'b0;
    model_reset();
    test_reset();
    test_fairness();
    test_phase_hold();
    test_backpressure();
    test_len_guard();
    test_idle_phase();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ni_inject_scheduler.md
Name: ni_inject_scheduler

Overview:
- Shares the NI injection port between NUM_REQ local packet sources.
- Uses round-robin arbitration with packet-level (wormhole) grant hold.
- Flits move only while mode_i = 1. mode_i is the NI send phase, toggled every clk_div_8_to_NI tick by the NI mode controller.
- Sits between the core-side packet queues and the NI serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, flit width in bits.
- MAX_FLITS, 16, longest legal packet in flits; the guard limit for runaway packets.

Ports:
- clk  in  1  main clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode_i  in  1  NI phase: 1 = inject phase, 0 = hold.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_data  in  NUM_REQ*DATA_W  per-requester flit; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  per-requester last-flit marker.
- req_ready  out  NUM_REQ  per-requester flit accepted.
- out_valid  out  1  flit valid to NI.
- out_data  out  DATA_W  flit to NI.
- out_last  out  1  last flit of packet.
- out_ready  in  1  NI accepts flit.
- grant_id  out  clog2(NUM_REQ)  currently granted requester; valid when busy = 1.
- busy  out  1  a packet is in progress.
- len_err  out  1  one-cycle pulse when a packet is truncated at MAX_FLITS.

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low. All state clears immediately on assertion; normal operation resumes on the first clk edge after deassertion.
- Reset values:
  - state = IDLE, busy = 0, grant_id = 0, len_err = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has highest priority first.
  - flit_cnt = 0.
  - out_valid = 0, req_ready = 0.
- State machine: IDLE, SEND.
- IDLE:
  - out_valid = 0; req_ready = 0.
  - If mode_i = 1 and any req_valid: select the first valid requester searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Register it into grant_id, set busy, clear flit_cnt, go to SEND.
  - If mode_i = 0: no arbitration; stay in IDLE.
- SEND (outputs combinational from the grant register):
  - out_valid = mode_i & req_valid[g].
  - out_data = req_data[g].
  - out_last = req_last[g] | (flit_cnt == MAX_FLITS-1).
  - req_ready[g] = mode_i & out_ready; all other req_ready bits = 0.
- Transfer: out_valid & out_ready. On each transfer flit_cnt increments.
- Packet end: a transfer with out_last = 1 ends the packet. Then:
  - rr_ptr = g.
  - busy = 0.
  - state = IDLE.
  - flit_cnt = 0.
- Length guard: if the packet ends because flit_cnt reached MAX_FLITS-1 while req_last[g] = 0, len_err pulses high for exactly one cycle (the cycle after the transfer). Any remaining flits from that source are arbitrated as a new packet.
- Phase drop mid-packet: mode_i falling to 0 freezes the transfer (out_valid = 0, req_ready = 0). The grant, flit_cnt and state are held. Transfer resumes when mode_i returns to 1. No re-arbitration occurs mid-packet.
- Requester bubble: req_valid[g] = 0 in SEND stalls without losing the grant.
- Latency:
  - Arbitration takes 1 cycle (the IDLE decision).
  - The first flit can transfer in the first SEND cycle.
  - Minimum packet spacing is 1 idle cycle between packets.
- Single-flit packet: transfers in one SEND cycle.
- Simultaneous events: mode_i and out_ready are sampled in the same cycle; both must be 1 for a transfer.
- Flit count width: flit_cnt is clog2(MAX_FLITS) bits and never wraps because of the guard.

Decomposition:
- Shared package ni_pkg holds:
  - the state enum {IDLE, SEND};
  - NI_DATA_W and NI_MAX_FLITS defaults;
  - a clog2-based width constant for grant_id.
- One sub-module: rr_arbiter. It is combinational, takes req[NUM_REQ] and ptr, and outputs gnt_onehot and gnt_idx. It is reusable by the NI ejection side.

Test Plan:
- Reset: assert reset_n = 0 mid-packet at cycle 5 -> out_valid, busy, len_err drop to 0 immediately. After release, requester 0 wins the first arbitration.
- Fairness: NUM_REQ = 4, all requesters continuously valid with 2-flit packets, mode_i = 1, out_ready = 1 -> grant order 0, 1, 2, 3, 0. Each packet is 2 transfers followed by 1 idle cycle.
- Phase hold: 4-flit packet from requester 2, mode_i drops to 0 after flit 2 for 8 cycles -> no transfers and no req_ready during the hold, grant_id stays 2. Flits 3-4 follow once mode_i = 1.
- Backpressure/bubble: out_ready toggling 1, 0, 1, 0 and req_valid gap on requester 1 -> no flit duplicated or dropped. out_data order matches the source exactly.
- Length guard: MAX_FLITS = 16, requester 3 sends 20 flits without last -> out_last asserted on flit 16 and len_err pulses once. Flits 17-20 emerge as a separate packet after re-arbitration.
- Idle phase: requests present with mode_i = 0 -> state stays IDLE, busy = 0. Arbitration occurs on the first cycle mode_i = 1.
